// File: rtl/baud_rate_gen_if.sv
// Control, configuration and tick bundle of the fractional baud-rate generator.
// The master side drives run/resync/config; the slave side (the generator) produces ticks.
interface baud_rate_gen_if #(
   parameter int ACC_W   = 16,
   parameter int OS_RATE = 16
);
   localparam int IDX_W = $clog2(OS_RATE);

   logic             enable;
   logic             resync;
   logic [ACC_W-1:0] cfg_inc;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             os_tick;
   logic             bit_tick;
   logic [IDX_W-1:0] os_index;

   modport master (
      output enable, resync, cfg_inc, cfg_valid,
      input  cfg_ready, os_tick, bit_tick, os_index
   );

   modport slave (
      input  enable, resync, cfg_inc, cfg_valid,
      output cfg_ready, os_tick, bit_tick, os_index
   );
endinterface

// File: rtl/baud_rate_gen.sv
// Phase-accumulator baud generator: os_tick at f_clk*inc/2^ACC_W, bit_tick every OS_RATE os_ticks.
// A new increment is staged and swapped in only at a bit boundary, while idle, or on resync.
module baud_rate_gen #(
   parameter int ACC_W       = 16,
   parameter int OS_RATE     = 16,
   parameter int DEFAULT_INC = 1208
) (
   input  logic           clk,
   input  logic           rst,
   baud_rate_gen_if.slave bus
);
   localparam int IDX_W = $clog2(OS_RATE);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OS_RATE - 1);
   localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OS_RATE / 2);
   localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);

   logic [ACC_W-1:0] acc_reg;
   logic [ACC_W-1:0] inc_active_reg;
   logic [ACC_W-1:0] staged_reg;
   logic             staged_full_reg;
   logic             os_tick_reg;
   logic             bit_tick_reg;
   logic [IDX_W-1:0] os_index_reg;

   logic [ACC_W:0]   sum;
   logic             carry;
   logic             bit_next;
   logic             apply;
   logic             accept;

   always_comb begin
      sum      = {1'b0, acc_reg} + {1'b0, inc_active_reg};
      carry    = sum[ACC_W];
      bit_next = bus.enable && !bus.resync && carry && (os_index_reg == IDX_LAST);
      // Swap only where no partial bit would be stretched or shrunk.
      apply    = staged_full_reg && (bit_next || !bus.enable || bus.resync);
      // Accept requires an empty stage, so accept and apply never coincide.
      accept   = bus.cfg_valid && !staged_full_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg         <= '0;
         inc_active_reg  <= INC_RST;
         staged_reg      <= '0;
         staged_full_reg <= 1'b0;
         os_tick_reg     <= 1'b0;
         bit_tick_reg    <= 1'b0;
         os_index_reg    <= '0;
      end else begin
         if (bus.resync) begin
            acc_reg      <= '0;
            os_index_reg <= IDX_MID;
            os_tick_reg  <= 1'b0;
            bit_tick_reg <= 1'b0;
         end else if (!bus.enable) begin
            acc_reg      <= '0;
            os_index_reg <= '0;
            os_tick_reg  <= 1'b0;
            bit_tick_reg <= 1'b0;
         end else begin
            acc_reg      <= sum[ACC_W-1:0];
            os_tick_reg  <= carry;
            bit_tick_reg <= bit_next;
            if (carry) begin
               os_index_reg <= (os_index_reg == IDX_LAST) ? '0 : os_index_reg + 1'b1;
            end
         end

         if (apply) begin
            inc_active_reg  <= staged_reg;
            staged_full_reg <= 1'b0;
         end else if (accept) begin
            staged_reg      <= bus.cfg_inc;
            staged_full_reg <= 1'b1;
         end
      end
   end

   assign bus.cfg_ready = !staged_full_reg;
   assign bus.os_tick   = os_tick_reg;
   assign bus.bit_tick  = bit_tick_reg;
   assign bus.os_index  = os_index_reg;
endmodule

// File: tb/tb_baud_rate_gen.sv
// Randomized and directed bench for baud_rate_gen against an arithmetic phase model.
module tb_baud_rate_gen;
   localparam int ACC_W   = 4;
   localparam int OS_RATE = 4;
   localparam int DEF_INC = 3;
   localparam int MODULUS = 1 << ACC_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   baud_rate_gen_if #(.ACC_W(ACC_W), .OS_RATE(OS_RATE)) bus ();

   baud_rate_gen #(
      .ACC_W(ACC_W), .OS_RATE(OS_RATE), .DEFAULT_INC(DEF_INC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference: fractional phase kept as an integer numerator over 2^ACC_W.
   int m_frac, m_pos, m_inc, m_staged;
   bit m_full, e_os, e_bit;

   int cyc = 0;
   int n_os_obs, n_bit_obs, last_os;
   bit spacing_chk = 1'b0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_frac = 0; m_pos = 0; m_inc = DEF_INC; m_staged = 0;
      m_full = 1'b0; e_os = 1'b0; e_bit = 1'b0;
   endtask

   task automatic model_edge();
      if (bus.resync) begin
         m_frac = 0; m_pos = OS_RATE / 2; e_os = 1'b0; e_bit = 1'b0;
      end else if (!bus.enable) begin
         m_frac = 0; m_pos = 0; e_os = 1'b0; e_bit = 1'b0;
      end else begin
         m_frac = m_frac + m_inc;
         e_os   = (m_frac >= MODULUS);
         m_frac = m_frac % MODULUS;
         if (e_os) m_pos = (m_pos + 1) % OS_RATE;
         e_bit  = e_os && (m_pos == 0);
      end
      if (m_full && (e_bit || !bus.enable || bus.resync)) begin
         m_inc  = m_staged;
         m_full = 1'b0;
      end else if (bus.cfg_valid && !m_full) begin
         m_staged = int'(bus.cfg_inc);
         m_full   = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_eq("os_tick",   int'(bus.os_tick),   int'(e_os));
      check_eq("bit_tick",  int'(bus.bit_tick),  int'(e_bit));
      check_eq("os_index",  int'(bus.os_index),  m_pos);
      check_eq("cfg_ready", int'(bus.cfg_ready), int'(!m_full));
      if (bus.os_tick) begin
         n_os_obs++;
         if (spacing_chk && last_os >= 0)
            check_eq("spacing_5_or_6", int'((cyc - last_os == 5) || (cyc - last_os == 6)), 1);
         last_os = cyc;
      end
      if (bus.bit_tick) n_bit_obs++;
   endtask

   task automatic set_cfg(input int v);
      bus.cfg_inc   = ACC_W'(v);
      bus.cfg_valid = 1'b1;
      step();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic load_inc(input int v);
      bus.enable = 1'b0;
      set_cfg(v);
      step();
      bus.enable = 1'b1;
   endtask

   task automatic wait_bit(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         step();
         found = bus.bit_tick;
      end
      check_eq(tag, int'(found), 1);
   endtask

   initial begin
      int first_tick;
      bus.enable = 1'b0; bus.resync = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_inc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_os_tick",   int'(bus.os_tick),   0);
      check_eq("rst_bit_tick",  int'(bus.bit_tick),  0);
      check_eq("rst_os_index",  int'(bus.os_index),  0);
      check_eq("rst_cfg_ready", int'(bus.cfg_ready), 1);
      rst = 1'b0;

      // Default increment: 16 cycles x 3 = 48 = exactly 3 overflows.
      bus.enable = 1'b1; n_os_obs = 0; last_os = -1;
      repeat (16) step();
      check_eq("default_inc_ticks", n_os_obs, 3);

      // Steady rate with inc=4.
      load_inc(4);
      n_os_obs = 0; n_bit_obs = 0;
      repeat (32) step();
      check_eq("steady_os_count", n_os_obs, 8);
      check_eq("steady_bit_count", n_bit_obs, 2);

      // Fractional rate inc=3 over 160 cycles.
      load_inc(3);
      n_os_obs = 0; last_os = -1; spacing_chk = 1'b1;
      repeat (160) step();
      spacing_chk = 1'b0;
      check_eq("frac_os_count", n_os_obs, 30);

      // Resync at os_index=1.
      load_inc(4);
      for (int i = 0; i < 32 && bus.os_index != 1; i++) step();
      check_eq("reach_idx1", int'(bus.os_index), 1);
      bus.resync = 1'b1;
      step();
      bus.resync = 1'b0;
      check_eq("resync_no_tick", int'(bus.os_tick), 0);
      check_eq("resync_mid_idx", int'(bus.os_index), OS_RATE / 2);
      for (int i = 1; i <= 8; i++) begin
         step();
         check_eq($sformatf("resync_os_%0d", i), int'(bus.os_tick), int'(i == 4 || i == 8));
         check_eq($sformatf("resync_bit_%0d", i), int'(bus.bit_tick), int'(i == 8));
      end

      // Deferred config: 8 accepted mid-bit, a second offer (1) while busy is ignored.
      wait_bit("wait_bit_pre_cfg");
      repeat (2) step();
      set_cfg(8);
      check_eq("cfg_ready_low", int'(bus.cfg_ready), 0);
      bus.cfg_inc = ACC_W'(1); bus.cfg_valid = 1'b1;
      wait_bit("wait_bit_apply");
      bus.cfg_valid = 1'b0;
      check_eq("cfg_ready_back", int'(bus.cfg_ready), 1);
      n_os_obs = 0;
      repeat (8) step();
      check_eq("fast_os_count", n_os_obs, 4);

      // Disable mid-bit for 3 cycles, then re-enable.
      load_inc(4);
      for (int i = 0; i < 32 && bus.os_index != 2; i++) step();
      check_eq("reach_idx2", int'(bus.os_index), 2);
      bus.enable = 1'b0;
      repeat (3) begin
         step();
         check_eq("dis_no_tick", int'(bus.os_tick), 0);
         check_eq("dis_idx0", int'(bus.os_index), 0);
      end
      bus.enable = 1'b1;
      first_tick = 0;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (bus.os_tick && first_tick == 0) first_tick = i;
      end
      check_eq("reenable_first_tick", first_tick, 4);

      // Asynchronous reset mid-cycle with a staged value pending.
      set_cfg(2);
      check_eq("pre_rst_ready", int'(bus.cfg_ready), 0);
      #1 rst = 1'b1;
      #1;
      check_eq("arst_os_tick",   int'(bus.os_tick),   0);
      check_eq("arst_bit_tick",  int'(bus.bit_tick),  0);
      check_eq("arst_os_index",  int'(bus.os_index),  0);
      check_eq("arst_cfg_ready", int'(bus.cfg_ready), 1);
      #1 rst = 1'b0;
      model_reset();
      n_os_obs = 0;
      repeat (16) step();
      check_eq("post_rst_default_ticks", n_os_obs, 3);

      // Random mix of enable, resync and config traffic.
      for (int i = 0; i < 400; i++) begin
         bus.enable    = ($urandom_range(0, 9) != 0);
         bus.resync    = ($urandom_range(0, 24) == 0);
         bus.cfg_valid = ($urandom_range(0, 3) == 0);
         bus.cfg_inc   = ACC_W'($urandom_range(0, MODULUS - 1));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
